// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: two-requester DDR user-port arbiter with read-order tracking.
// Build option: DDR_ARB_FIXED_PRIO_EN gives requester 0 fixed priority.
module ddr_port_arbiter #(
  parameter int DATA_W        = 256,
  parameter int ADDR_W        = 32,
  parameter int RD_FIFO_DEPTH = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,

  input  logic                             i_s0_wr_req,
  input  logic [ADDR_W-1:0]                i_s0_wr_addr,
  input  logic [DATA_W-1:0]                i_s0_wr_data,
  input  logic [DATA_W/8-1:0]              i_s0_wr_be,
  output logic                             o_s0_wr_ack,
  input  logic                             i_s0_rd_req,
  input  logic [ADDR_W-1:0]                i_s0_rd_addr,
  output logic                             o_s0_rd_ack,
  output logic [DATA_W-1:0]                o_s0_rd_data,
  output logic                             o_s0_rd_data_valid,

  input  logic                             i_s1_wr_req,
  input  logic [ADDR_W-1:0]                i_s1_wr_addr,
  input  logic [DATA_W-1:0]                i_s1_wr_data,
  input  logic [DATA_W/8-1:0]              i_s1_wr_be,
  output logic                             o_s1_wr_ack,
  input  logic                             i_s1_rd_req,
  input  logic [ADDR_W-1:0]                i_s1_rd_addr,
  output logic                             o_s1_rd_ack,
  output logic [DATA_W-1:0]                o_s1_rd_data,
  output logic                             o_s1_rd_data_valid,

  output logic                             o_ddr_wr_req,
  output logic [ADDR_W-1:0]                o_ddr_wr_addr,
  output logic [DATA_W-1:0]                o_ddr_wr_data,
  output logic [DATA_W/8-1:0]              o_ddr_wr_be,
  input  logic                             i_ddr_wr_ack,
  output logic                             o_ddr_rd_req,
  output logic [ADDR_W-1:0]                o_ddr_rd_addr,
  input  logic                             i_ddr_rd_ack,
  input  logic [DATA_W-1:0]                i_ddr_rd_data,
  input  logic                             i_ddr_rd_data_valid,

  output logic                             o_busy,
  output logic [$clog2(RD_FIFO_DEPTH):0]   o_rd_outstanding,
  output logic                             o_err_underflow
);

  localparam int BE_W = DATA_W / 8;
  localparam int PW   = $clog2(RD_FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(RD_FIFO_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;

  logic [1:0]               state;
  logic                     gnt_id;
  logic [RD_FIFO_DEPTH-1:0] ord_q;
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [PW:0]              count;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic head_id;
  logic elig0;
  logic elig1;
  logic win;
  logic win_wr;
  logic grant;

  logic [ADDR_W-1:0] sel_wr_addr;
  logic [DATA_W-1:0] sel_wr_data;
  logic [BE_W-1:0]   sel_wr_be;
  logic [ADDR_W-1:0] sel_rd_addr;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign head_id    = ord_q[rd_ptr];

  assign elig0 = i_s0_wr_req | (i_s0_rd_req & ~fifo_full);
  assign elig1 = i_s1_wr_req | (i_s1_rd_req & ~fifo_full);
  assign grant = (state == IDLE) & (elig0 | elig1);

`ifdef DDR_ARB_FIXED_PRIO_EN
  assign win = ~elig0;
`else
  logic last_id;

  // Remember who was granted last so the other side wins the next tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_id <= 1'b1;
    end else if (grant) begin
      last_id <= win;
    end
  end

  assign win = (elig0 & elig1) ? ~last_id : elig1;
`endif

  assign win_wr      = win ? i_s1_wr_req  : i_s0_wr_req;
  assign sel_wr_addr = win ? i_s1_wr_addr : i_s0_wr_addr;
  assign sel_wr_data = win ? i_s1_wr_data : i_s0_wr_data;
  assign sel_wr_be   = win ? i_s1_wr_be   : i_s0_wr_be;
  assign sel_rd_addr = win ? i_s1_rd_addr : i_s0_rd_addr;

  assign push = (state == RD) & i_ddr_rd_ack;
  assign pop  = i_ddr_rd_data_valid & ~fifo_empty;

  // Transaction FSM: grant, hold the DDR request until acked, back to idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      gnt_id        <= 1'b0;
      o_ddr_wr_req  <= 1'b0;
      o_ddr_rd_req  <= 1'b0;
      o_ddr_wr_addr <= '0;
      o_ddr_wr_data <= '0;
      o_ddr_wr_be   <= '0;
      o_ddr_rd_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            gnt_id <= win;
            if (win_wr) begin
              state         <= WR;
              o_ddr_wr_req  <= 1'b1;
              o_ddr_wr_addr <= sel_wr_addr;
              o_ddr_wr_data <= sel_wr_data;
              o_ddr_wr_be   <= sel_wr_be;
            end else begin
              state         <= RD;
              o_ddr_rd_req  <= 1'b1;
              o_ddr_rd_addr <= sel_rd_addr;
            end
          end
        end
        WR: begin
          if (i_ddr_wr_ack) begin
            state        <= IDLE;
            o_ddr_wr_req <= 1'b0;
          end
        end
        RD: begin
          if (i_ddr_rd_ack) begin
            state        <= IDLE;
            o_ddr_rd_req <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          o_ddr_wr_req <= 1'b0;
          o_ddr_rd_req <= 1'b0;
        end
      endcase
    end
  end

  // Read-order FIFO of requester IDs, one entry per accepted read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ord_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ord_q[wr_ptr] <= gnt_id;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky flag for read data arriving with nothing outstanding.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_underflow <= 1'b0;
    end else if (i_ddr_rd_data_valid & fifo_empty) begin
      o_err_underflow <= 1'b1;
    end
  end

  assign o_s0_wr_ack = (state == WR) & i_ddr_wr_ack & ~gnt_id;
  assign o_s1_wr_ack = (state == WR) & i_ddr_wr_ack &  gnt_id;
  assign o_s0_rd_ack = (state == RD) & i_ddr_rd_ack & ~gnt_id;
  assign o_s1_rd_ack = (state == RD) & i_ddr_rd_ack &  gnt_id;

  assign o_s0_rd_data       = i_ddr_rd_data;
  assign o_s1_rd_data       = i_ddr_rd_data;
  assign o_s0_rd_data_valid = pop & ~head_id;
  assign o_s1_rd_data_valid = pop &  head_id;

  assign o_busy           = (state != IDLE);
  assign o_rd_outstanding = count;

endmodule
